wbuart_arb: RTL

WBUART_ARB -- requirements
Module: wbuart_arb

---
 rtl/wbuart_arb_pkg.sv | 18 +
 rtl/wbuart_arb_timer.sv | 29 ++
 rtl/wbuart_arb.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/wbuart_arb_pkg.sv
// Shared types and constants for the two-master UART Wishbone arbiter.
package wbuart_arb_pkg;

  // Encodings double as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_e;

  localparam logic [31:0] WIN_MASK     = 32'hFFFF_FF00;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  function automatic logic in_window(input logic [31:0] adr, input logic [31:0] base);
    return (adr & WIN_MASK) == base;
  endfunction

endpackage

// File: rtl/wbuart_arb_timer.sv
// Stall watchdog: counts owner wait cycles and pulses fire_o when TIMEOUT_CYCLES is reached.
module wbuart_arb_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic clr_i,
  output logic fire_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign fire_o = run_i && (cnt_q == CW'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || fire_o) cnt_d = '0;
    else if (run_i)      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wbuart_arb.sv
// Two-master Wishbone arbiter in front of the UART wrapper, alternating on contention.
// Define WBUART_ARB_TIMEOUT_EN to add the stalled-slave forced termination.
module wbuart_arb
  import wbuart_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h3001_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_wbs_cyc_i,
  input  logic        m0_wbs_stb_i,
  input  logic        m0_wbs_we_i,
  input  logic [31:0] m0_wbs_adr_i,
  input  logic [31:0] m0_wbs_dat_i,
  input  logic [3:0]  m0_wbs_sel_i,
  output logic        m0_wbs_ack_o,
  output logic [31:0] m0_wbs_dat_o,
  input  logic        m1_wbs_cyc_i,
  input  logic        m1_wbs_stb_i,
  input  logic        m1_wbs_we_i,
  input  logic [31:0] m1_wbs_adr_i,
  input  logic [31:0] m1_wbs_dat_i,
  input  logic [3:0]  m1_wbs_sel_i,
  output logic        m1_wbs_ack_o,
  output logic [31:0] m1_wbs_dat_o,
  output logic        s_wbs_cyc_o,
  output logic        s_wbs_stb_o,
  output logic        s_wbs_we_o,
  output logic [31:0] s_wbs_adr_o,
  output logic [31:0] s_wbs_dat_o,
  output logic [3:0]  s_wbs_sel_o,
  input  logic        s_wbs_ack_i,
  input  logic [31:0] s_wbs_dat_i,
  output logic [1:0]  gnt_o,
  output logic        timeout_o
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;   // 1: m1 served last
  logic       win0, win1, req0, req1;
  logic       fire;

  assign win0 = in_window(m0_wbs_adr_i, BASE_ADDR);
  assign win1 = in_window(m1_wbs_adr_i, BASE_ADDR);
  assign req0 = m0_wbs_cyc_i && m0_wbs_stb_i && win0;
  assign req1 = m1_wbs_cyc_i && m1_wbs_stb_i && win1;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0 && (!req1 || last_q)) state_d = OWN0;
        else if (req1)                 state_d = OWN1;
      end
      OWN0:    if (!m0_wbs_cyc_i) state_d = req1 ? OWN1 : IDLE;
      OWN1:    if (!m1_wbs_cyc_i) state_d = req0 ? OWN0 : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == OWN0 && state_q != OWN0) last_d = 1'b0;
    if (state_d == OWN1 && state_q != OWN1) last_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign gnt_o = state_q;

  // Slave side kept apart from the return path so fire never loops back into stb.
  always_comb begin
    s_wbs_cyc_o = 1'b0;
    s_wbs_stb_o = 1'b0;
    s_wbs_we_o  = 1'b0;
    s_wbs_adr_o = '0;
    s_wbs_dat_o = '0;
    s_wbs_sel_o = '0;
    case (state_q)
      OWN0: begin
        s_wbs_cyc_o = m0_wbs_cyc_i && win0;
        s_wbs_stb_o = m0_wbs_stb_i && win0;
        s_wbs_we_o  = m0_wbs_we_i;
        s_wbs_adr_o = m0_wbs_adr_i;
        s_wbs_dat_o = m0_wbs_dat_i;
        s_wbs_sel_o = m0_wbs_sel_i;
      end
      OWN1: begin
        s_wbs_cyc_o = m1_wbs_cyc_i && win1;
        s_wbs_stb_o = m1_wbs_stb_i && win1;
        s_wbs_we_o  = m1_wbs_we_i;
        s_wbs_adr_o = m1_wbs_adr_i;
        s_wbs_dat_o = m1_wbs_dat_i;
        s_wbs_sel_o = m1_wbs_sel_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    m0_wbs_ack_o = 1'b0;
    m0_wbs_dat_o = '0;
    m1_wbs_ack_o = 1'b0;
    m1_wbs_dat_o = '0;
    case (state_q)
      OWN0: begin
        m0_wbs_ack_o = s_wbs_ack_i || fire;
        m0_wbs_dat_o = fire ? TIMEOUT_DATA : s_wbs_dat_i;
      end
      OWN1: begin
        m1_wbs_ack_o = s_wbs_ack_i || fire;
        m1_wbs_dat_o = fire ? TIMEOUT_DATA : s_wbs_dat_i;
      end
      default: ;
    endcase
  end

`ifdef WBUART_ARB_TIMEOUT_EN
  logic timer_run, timer_clr;
  logic timeout_q, timeout_d;

  assign timer_run = (state_q != IDLE) && s_wbs_stb_o && !s_wbs_ack_i;
  assign timer_clr = s_wbs_ack_i || (state_d != state_q);

  wbuart_arb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .run_i  (timer_run),
    .clr_i  (timer_clr),
    .fire_o (fire)
  );

  always_comb timeout_d = timeout_q || fire;

  always_ff @(posedge clk_i) begin
    if (rst_i) timeout_q <= 1'b0;
    else       timeout_q <= timeout_d;
  end

  assign timeout_o = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES != 0);
  assign fire       = 1'b0;
  assign timeout_o  = 1'b0;
`endif

endmodule
